// File: rtl/ir_prefetch_queue_pkg.sv
// Shared defaults and helpers for the instruction prefetch queue.
package ir_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int OPW_DEF   = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Returns the top opw bits of a width-bit word, right-aligned.
  function automatic logic [63:0] op_field(input logic [63:0] word, input int width,
                                           input int opw);
    return (word >> (width - opw)) & ((64'd1 << opw) - 64'd1);
  endfunction

endpackage

// File: rtl/ir_prefetch_queue_fifo_mem.sv
// Circular word store with read/write pointers and occupancy count; no IR or bypass logic.
module ir_fifo_mem
  import ir_pkg::*;
#(
  parameter int EW    = 16,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [EW-1:0]              wdata,
  output logic [EW-1:0]              rdata,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch queue, with empty-queue bypass.
// Optional parity checking on IR load is enabled by defining IR_PARITY_EN.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        Buss,
`ifdef IR_PARITY_EN
  input  logic                    Buss_par,
`endif
  input  logic                    ldIR,
  input  logic                    advIR,
  input  logic                    flush,
  output logic [WIDTH-1:0]        IR,
  output logic                    IR_valid,
  output logic [OPW-1:0]          opcode,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf,
  output logic                    unf,
  output logic                    IR_par_err
);

`ifdef IR_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  logic [EW-1:0]    wdata, rdata;
  logic [WIDTH-1:0] load_word;
  logic             do_push, do_pop, load_ok;

`ifdef IR_PARITY_EN
  assign wdata = {Buss_par, Buss};
`else
  assign wdata = Buss;
`endif

  // A push during a pop at full is legal; a push into an empty queue on advance is a bypass.
  assign do_pop    = advIR && !empty && !flush;
  assign do_push   = ldIR && !flush && !(advIR && empty) && (!full || advIR);
  assign load_word = empty ? Buss : rdata[WIDTH-1:0];
  assign load_ok   = advIR && (!empty || ldIR);

  ir_fifo_mem #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .clear (flush),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      IR       <= '0;
      IR_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (flush) begin
      IR_valid <= 1'b0;
    end else if (advIR) begin
      if (load_ok) begin
        IR       <= load_word;
        IR_valid <= 1'b1;
      end else begin
        IR_valid <= 1'b0;
        unf      <= 1'b1;
      end
    end else if (ldIR && full) begin
      ovf <= 1'b1;
    end
  end

`ifdef IR_PARITY_EN
  logic load_par;
  assign load_par = empty ? Buss_par : rdata[WIDTH];

  always_ff @(posedge clk) begin
    if (!reset)
      IR_par_err <= 1'b0;
    else if (!flush && load_ok && (load_par != ^load_word))
      IR_par_err <= 1'b1;
  end
`else
  assign IR_par_err = 1'b0;
`endif

  assign opcode = OPW'(op_field(64'(IR), WIDTH, OPW));

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed plus randomized bench for ir_prefetch_queue against a queue-based reference model.
module tb_ir_prefetch_queue;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  logic reset, ldIR, advIR, flush, Buss_par;
  logic [WIDTH-1:0] Buss;
  logic [WIDTH-1:0] IR;
  logic [OPW-1:0]   opcode;
  logic [2:0]       count;
  logic IR_valid, full, empty, ovf, unf, IR_par_err;

  always #5 clk = ~clk;

  ir_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .Buss       (Buss),
`ifdef IR_PARITY_EN
    .Buss_par   (Buss_par),
`endif
    .ldIR       (ldIR),
    .advIR      (advIR),
    .flush      (flush),
    .IR         (IR),
    .IR_valid   (IR_valid),
    .opcode     (opcode),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .unf        (unf),
    .IR_par_err (IR_par_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: queue of {parity, word}.
  logic [WIDTH:0]   mq[$];
  logic [WIDTH-1:0] m_ir;
  logic m_valid, m_ovf, m_unf, m_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_load(input logic [WIDTH:0] e);
    m_ir    = e[WIDTH-1:0];
    m_valid = 1'b1;
`ifdef IR_PARITY_EN
    if (e[WIDTH] != ^e[WIDTH-1:0]) m_perr = 1'b1;
`endif
  endtask

  task automatic model_step(input logic r, ld, adv, fl, input logic [WIDTH-1:0] b, input logic p);
    logic [WIDTH:0] e;
    if (!r) begin
      mq.delete();
      m_ir = '0; m_valid = 0; m_ovf = 0; m_unf = 0; m_perr = 0;
    end else if (fl) begin
      mq.delete();
      m_valid = 0;
    end else if (adv) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        model_load(e);
        if (ld) mq.push_back({p, b});
      end else if (ld) begin
        model_load({p, b});
      end else begin
        m_valid = 0;
        m_unf   = 1;
      end
    end else if (ld) begin
      if (mq.size() < DEPTH) mq.push_back({p, b});
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] ir_tmp;
    ir_tmp = m_ir;
    check("IR", 32'(IR), 32'(m_ir));
    check("IR_valid", 32'(IR_valid), 32'(m_valid));
    check("opcode", 32'(opcode), 32'(ir_tmp[WIDTH-1 -: OPW]));
    check("count", 32'(count), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
    check("IR_par_err", 32'(IR_par_err), 32'(m_perr));
  endtask

  task automatic cyc(input logic r, ld, adv, fl, input logic [WIDTH-1:0] b, input logic p);
    reset = r; ldIR = ld; advIR = adv; flush = fl; Buss = b; Buss_par = p;
    model_step(r, ld, adv, fl, b, p);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    reset = 0; ldIR = 1; advIR = 1; flush = 0; Buss = 16'hFFFF; Buss_par = 0;

    // Reset overrides active ldIR/advIR.
    cyc(0, 1, 1, 0, 16'hFFFF, 0);
    cyc(0, 1, 1, 0, 16'hFFFF, 0);
    check("rst_IR", 32'(IR), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) begin
      w = 16'(16'h1111 * i);
      cyc(1, 1, 0, 0, w, ^w);
    end
    check("fill_full", 32'(full), 32'h1);
    cyc(1, 1, 0, 0, 16'h5555, ^16'h5555);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_count", 32'(count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 1, 0, 16'h0, 0);
      check("drain_ir", 32'(IR), 32'(16'(16'h1111 * i)));
    end
    check("drain_empty", 32'(empty), 32'h1);

    // Bypass then underflow.
    cyc(1, 1, 1, 0, 16'hA5C3, ^16'hA5C3);
    check("bypass_ir", 32'(IR), 32'hA5C3);
    check("bypass_op", 32'(opcode), 32'hA);
    check("bypass_cnt", 32'(count), 32'h0);
    cyc(1, 0, 1, 0, 16'h0, 0);
    check("unf_hold_ir", 32'(IR), 32'hA5C3);
    check("unf_valid", 32'(IR_valid), 32'h0);
    check("unf_set", 32'(unf), 32'h1);

    // Simultaneous push/pop at full, then drain across pointer wrap.
    cyc(0, 0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 4; i++) begin
      w = 16'(16'h1111 * i);
      cyc(1, 1, 0, 0, w, ^w);
    end
    cyc(1, 1, 1, 0, 16'h9999, ^16'h9999);
    check("pp_ir", 32'(IR), 32'h1111);
    check("pp_count", 32'(count), 32'h4);
    check("pp_ovf", 32'(ovf), 32'h0);
    cyc(1, 0, 1, 0, 16'h0, 0); check("wrap_ir2", 32'(IR), 32'h2222);
    cyc(1, 0, 1, 0, 16'h0, 0); check("wrap_ir3", 32'(IR), 32'h3333);
    cyc(1, 0, 1, 0, 16'h0, 0); check("wrap_ir4", 32'(IR), 32'h4444);
    cyc(1, 0, 1, 0, 16'h0, 0); check("wrap_ir9", 32'(IR), 32'h9999);

    // Flush wins over ldIR/advIR; the next word lands at the head.
    cyc(1, 1, 0, 0, 16'hAAAA, ^16'hAAAA);
    cyc(1, 1, 0, 0, 16'hBBBB, ^16'hBBBB);
    cyc(1, 1, 0, 0, 16'hCCCC, ^16'hCCCC);
    cyc(1, 1, 1, 1, 16'h7777, ^16'h7777);
    check("flush_cnt", 32'(count), 32'h0);
    check("flush_ir", 32'(IR), 32'h9999);
    check("flush_valid", 32'(IR_valid), 32'h0);
    cyc(1, 1, 0, 0, 16'h1234, ^16'h1234);
    cyc(1, 0, 1, 0, 16'h0, 0);
    check("post_flush_ir", 32'(IR), 32'h1234);

`ifdef IR_PARITY_EN
    cyc(1, 1, 0, 0, 16'h0001, 1'b0);
    cyc(1, 0, 1, 0, 16'h0, 0);
    check("par_ir", 32'(IR), 32'h0001);
    check("par_err", 32'(IR_par_err), 32'h1);
    cyc(1, 1, 0, 0, 16'h0002, 1'b1);
    cyc(1, 0, 1, 0, 16'h0, 0);
    check("par_sticky", 32'(IR_par_err), 32'h1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, ld, adv, fl, p;
      w   = 16'($urandom);
      r   = ($urandom_range(0, 63) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      ld  = ($urandom_range(0, 9) < 6);
      adv = ($urandom_range(0, 9) < 5);
      p   = (^w) ^ ($urandom_range(0, 15) == 0);
      cyc(r, ld, adv, fl, w, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised successor to the single-word instruction register. It places a DEPTH-entry prefetch queue between Buss and the IR, so fetch can run ahead of execute. The IR loads from the queue head on an advance request, with bypass when the queue is empty. It exposes the decoded opcode field, queue status and sticky error flags to the control unit.

Parameters:
WIDTH, 16, instruction/Buss width in bits
DEPTH, 4, queue entries; power of 2, >= 2
OPW, 4, opcode field width; opcode = IR[WIDTH-1 -: OPW]

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset (asserted when 0)
Buss  in  WIDTH  instruction word from memory bus
ldIR  in  1  enqueue Buss into queue tail this cycle
advIR  in  1  load IR with next instruction (head, or Buss on bypass)
flush  in  1  discard queued words (branch taken)
IR  out  WIDTH  current instruction register
IR_valid  out  1  IR holds an instruction not yet superseded by flush/underflow
opcode  out  OPW  IR[WIDTH-1 -: OPW], combinational from IR
count  out  $clog2(DEPTH+1)  queued words (excludes IR)
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf  out  1  sticky: ldIR dropped because queue full
unf  out  1  sticky: advIR with nothing to load
IR_par_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (reset==0 at posedge): IR=0, IR_valid=0, count=0, read/write pointers=0, ovf=unf=IR_par_err=0. Queue contents are don't-care. Reset overrides all other inputs.
- Priority per cycle: reset > flush > (advIR, ldIR).
- flush: count<=0, pointers<=0, IR_valid<=0. IR value is held. ldIR/advIR in the same cycle are ignored. Sticky flags are unchanged.
- advIR, count>0: IR<=head, pop, IR_valid<=1. A simultaneous ldIR enqueues Buss; count is unchanged.
- advIR, count==0, ldIR=1: bypass. IR<=Buss, IR_valid<=1, nothing enqueued, count stays 0.
- advIR, count==0, ldIR=0: IR held, IR_valid<=0, unf<=1.
- ldIR alone, not full: write Buss at tail, count+1.
- ldIR alone, full: word dropped, ovf<=1, state otherwise unchanged.
- ldIR+advIR when full: pop and push both occur, no overflow, count stays DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- full/empty/count are registered-state derived (no combinational path from inputs).
- Latency: Buss->IR is 1 cycle on bypass; otherwise the word becomes visible on IR the cycle after the advIR that pops it. IR is stable between advances.
- Sticky flags clear only on reset.

Optional Feature:
Macro IR_PARITY_EN.
- Defined: adds input Buss_par (1 bit, even parity of Buss). Each entry stores WIDTH+1 bits. When a word is loaded into IR (pop or bypass) and stored parity != ^word, IR_par_err<=1 (sticky). The faulty word still loads.
- Undefined: no Buss_par port, no parity storage, IR_par_err tied 0.

Decomposition:
- Package ir_pkg holds:
  - default WIDTH/DEPTH/OPW constants
  - a count-width function (clog2(DEPTH+1))
  - an opcode-field extraction function
- One sub-module, ir_fifo_mem, holds the storage array plus read/write pointers and count. It takes push/pop/clear and has no bypass or IR logic.
- The top level holds IR, bypass muxing, priority logic and sticky flags.

Test Plan:
- Reset: drive reset=0 with ldIR=advIR=1, Buss=16'hFFFF -> IR=0, count=0, empty=1, all flags 0.
- Fill/drain: enqueue 16'h1111..16'h4444 (4 cycles) -> full=1. A 5th ldIR with 16'h5555 sets ovf=1 and count stays 4. Four advIR -> IR sequence 1111,2222,3333,4444, then empty=1.
- Bypass and underflow: queue empty, ldIR=advIR=1, Buss=16'hA5C3 -> next cycle IR=A5C3, opcode=4'hA, count=0. Then advIR alone -> IR=A5C3 held, IR_valid=0, unf=1.
- Simultaneous push/pop at full: queue full with 1111..4444, ldIR+advIR with Buss=16'h9999 -> IR=1111, count=4, ovf=0. Drain order 2222,3333,4444,9999 checks pointer wrap.
- Flush priority: 3 words queued, flush+advIR+ldIR in one cycle -> count=0, IR unchanged, IR_valid=0. The next ldIR enqueues at pointer 0.
- IR_PARITY_EN build: enqueue 16'h0001 with Buss_par=0 (wrong), advIR -> IR=0001, IR_par_err=1 and it stays 1 through further correct words.
